// File: rtl/comma_align_ctrl.sv
// comma_align_ctrl: K28.5 comma search / bitslip / lock sequencer for the 32-to-40 RX gearbox.
// Define COMMA_ALIGN_STATS_EN to add the lock_loss_count and total_slips statistics outputs.
module comma_align_ctrl #(
    parameter int SEARCH_WORDS  = 64,
    parameter int SETTLE_WORDS  = 4,
    parameter int LOCK_COMMAS   = 8,
    parameter int UNLOCK_ERRORS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [39:0] data_in,
    input  logic        valid_in,
    input  logic        slip_window,
    output logic        bitslip,
    output logic        locked,
    output logic [1:0]  comma_lane,
    output logic [3:0]  slip_count
`ifdef COMMA_ALIGN_STATS_EN
    ,
    output logic [15:0] lock_loss_count,
    output logic [15:0] total_slips
`endif
);

    localparam int WCNT_W = (SEARCH_WORDS > 1) ? $clog2(SEARCH_WORDS) : 1;
    localparam int SET_W  = (SETTLE_WORDS > 1) ? $clog2(SETTLE_WORDS) : 1;
    localparam int GOOD_W = $clog2(LOCK_COMMAS + 1);
    localparam int ERR_W  = (UNLOCK_ERRORS > 1) ? $clog2(UNLOCK_ERRORS) : 1;

    typedef enum logic [2:0] {
        ST_SEARCH = 3'd0,
        ST_SLIP   = 3'd1,
        ST_SETTLE = 3'd2,
        ST_VERIFY = 3'd3,
        ST_LOCKED = 3'd4
    } state_t;

    function automatic logic is_k28_5(input logic [9:0] sym);
        return (sym == 10'b0011111010) || (sym == 10'b1100000101);
    endfunction

    function automatic logic [3:0] aligned_lanes(input logic [39:0] d);
        logic [3:0] hit;
        hit = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            hit[i] = is_k28_5(d[39 - 10 * i -: 10]);
        end
        return hit;
    endfunction

    // Comma prefix starting anywhere except a symbol boundary means the word is skewed.
    function automatic logic has_misaligned(input logic [39:0] d);
        logic hit;
        hit = 1'b0;
        for (int b = 6; b <= 38; b++) begin
            if ((b != 29) && (b != 19) && (b != 9)) begin
                if ((d[b -: 7] == 7'b0011111) || (d[b -: 7] == 7'b1100000)) begin
                    hit = 1'b1;
                end else begin
                    hit = hit;
                end
            end else begin
                hit = hit;
            end
        end
        return hit;
    endfunction

    function automatic logic [1:0] first_lane(input logic [3:0] hit);
        if (hit[0]) begin
            return 2'd0;
        end else if (hit[1]) begin
            return 2'd1;
        end else if (hit[2]) begin
            return 2'd2;
        end else begin
            return 2'd3;
        end
    endfunction

    state_t              state_r, state_nx;
    logic [WCNT_W-1:0]   wcnt_r, wcnt_nx;
    logic                seen_r, seen_nx;
    logic [GOOD_W-1:0]   good_r, good_nx;
    logic [ERR_W-1:0]    err_r, err_nx;
    logic [SET_W-1:0]    settle_r, settle_nx;
    logic                locked_r, locked_nx;
    logic [1:0]          lane_r, lane_nx;
    logic [3:0]          slip_cnt_r, slip_cnt_nx;
    logic                slip_arm_r;

    logic [3:0]          lanes_s;
    logic                aligned_s;
    logic                mis_s;
    logic                win_end_s;
    logic [GOOD_W-1:0]   good_inc_s;

    assign lanes_s    = aligned_lanes(data_in);
    assign aligned_s  = valid_in & (|lanes_s);
    assign mis_s      = valid_in & has_misaligned(data_in);
    assign win_end_s  = (wcnt_r == WCNT_W'(SEARCH_WORDS - 1));
    assign good_inc_s = good_r + GOOD_W'(aligned_s & ~seen_r);

    // Next-state and counter update for the search/slip/settle/verify/locked sequence.
    always_comb begin
        state_nx    = state_r;
        wcnt_nx     = wcnt_r;
        seen_nx     = seen_r;
        good_nx     = good_r;
        err_nx      = err_r;
        settle_nx   = settle_r;
        locked_nx   = locked_r;
        lane_nx     = lane_r;
        slip_cnt_nx = slip_cnt_r;
        case (state_r)
            ST_SEARCH: begin
                if (!valid_in) begin
                    state_nx = ST_SEARCH;
                end else if (aligned_s && !mis_s) begin
                    // The word that found the comma already belongs to the first verify window.
                    state_nx = ST_VERIFY;
                    good_nx  = GOOD_W'(1);
                    lane_nx  = first_lane(lanes_s);
                    if (win_end_s) begin
                        wcnt_nx = '0;
                        seen_nx = 1'b0;
                    end else begin
                        wcnt_nx = wcnt_r + WCNT_W'(1);
                        seen_nx = 1'b1;
                    end
                end else if (mis_s || win_end_s) begin
                    state_nx = ST_SLIP;
                    wcnt_nx  = '0;
                    seen_nx  = 1'b0;
                end else begin
                    wcnt_nx = wcnt_r + WCNT_W'(1);
                end
            end
            ST_SLIP: begin
                if (slip_window) begin
                    state_nx    = ST_SETTLE;
                    settle_nx   = '0;
                    slip_cnt_nx = (slip_cnt_r == 4'hF) ? 4'hF : slip_cnt_r + 4'h1;
                end else begin
                    state_nx = ST_SLIP;
                end
            end
            ST_SETTLE: begin
                if (!valid_in) begin
                    state_nx = ST_SETTLE;
                end else if (settle_r == SET_W'(SETTLE_WORDS - 1)) begin
                    state_nx = ST_SEARCH;
                    wcnt_nx  = '0;
                    seen_nx  = 1'b0;
                end else begin
                    settle_nx = settle_r + SET_W'(1);
                end
            end
            ST_VERIFY: begin
                if (aligned_s) begin
                    lane_nx = first_lane(lanes_s);
                end else begin
                    lane_nx = lane_r;
                end
                if (!valid_in) begin
                    state_nx = ST_VERIFY;
                end else if (mis_s || (win_end_s && !(seen_r || aligned_s))) begin
                    state_nx = ST_SLIP;
                    good_nx  = '0;
                    wcnt_nx  = '0;
                    seen_nx  = 1'b0;
                end else if (win_end_s) begin
                    wcnt_nx = '0;
                    seen_nx = 1'b0;
                    good_nx = good_inc_s;
                    if (good_inc_s >= GOOD_W'(LOCK_COMMAS)) begin
                        state_nx  = ST_LOCKED;
                        locked_nx = 1'b1;
                        err_nx    = '0;
                    end else begin
                        state_nx = ST_VERIFY;
                    end
                end else begin
                    wcnt_nx = wcnt_r + WCNT_W'(1);
                    seen_nx = seen_r | aligned_s;
                    good_nx = good_inc_s;
                end
            end
            ST_LOCKED: begin
                if (aligned_s) begin
                    lane_nx = first_lane(lanes_s);
                end else begin
                    lane_nx = lane_r;
                end
                if (!valid_in) begin
                    state_nx = ST_LOCKED;
                end else if (mis_s || (win_end_s && !(seen_r || aligned_s))) begin
                    wcnt_nx = '0;
                    seen_nx = 1'b0;
                    if (err_r == ERR_W'(UNLOCK_ERRORS - 1)) begin
                        state_nx    = ST_SEARCH;
                        locked_nx   = 1'b0;
                        slip_cnt_nx = 4'h0;
                        err_nx      = '0;
                        good_nx     = '0;
                    end else begin
                        err_nx = err_r + ERR_W'(1);
                    end
                end else if (win_end_s) begin
                    wcnt_nx = '0;
                    seen_nx = 1'b0;
                    err_nx  = '0;
                end else begin
                    wcnt_nx = wcnt_r + WCNT_W'(1);
                    seen_nx = seen_r | aligned_s;
                end
            end
            default: begin
                state_nx    = ST_SEARCH;
                wcnt_nx     = '0;
                seen_nx     = 1'b0;
                good_nx     = '0;
                err_nx      = '0;
                settle_nx   = '0;
                locked_nx   = 1'b0;
                slip_cnt_nx = 4'h0;
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_SEARCH;
            wcnt_r     <= '0;
            seen_r     <= 1'b0;
            good_r     <= '0;
            err_r      <= '0;
            settle_r   <= '0;
            locked_r   <= 1'b0;
            lane_r     <= 2'd0;
            slip_cnt_r <= 4'h0;
            slip_arm_r <= 1'b0;
        end else begin
            state_r    <= state_nx;
            wcnt_r     <= wcnt_nx;
            seen_r     <= seen_nx;
            good_r     <= good_nx;
            err_r      <= err_nx;
            settle_r   <= settle_nx;
            locked_r   <= locked_nx;
            lane_r     <= lane_nx;
            slip_cnt_r <= slip_cnt_nx;
            slip_arm_r <= (state_nx == ST_SLIP);
        end
    end

    // The armed flag is gated by slip_window so a pulse can only land in a commit cycle.
    assign bitslip    = slip_arm_r & slip_window;
    assign locked     = locked_r;
    assign comma_lane = lane_r;
    assign slip_count = slip_cnt_r;

`ifdef COMMA_ALIGN_STATS_EN
    logic [15:0] lock_loss_r;
    logic [15:0] total_slips_r;

    // Saturating lifetime statistics, cleared only by rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_loss_r   <= 16'h0000;
            total_slips_r <= 16'h0000;
        end else begin
            if ((state_r == ST_LOCKED) && (state_nx == ST_SEARCH) && (lock_loss_r != 16'hFFFF)) begin
                lock_loss_r <= lock_loss_r + 16'h0001;
            end else begin
                lock_loss_r <= lock_loss_r;
            end
            if (bitslip && (total_slips_r != 16'hFFFF)) begin
                total_slips_r <= total_slips_r + 16'h0001;
            end else begin
                total_slips_r <= total_slips_r;
            end
        end
    end

    assign lock_loss_count = lock_loss_r;
    assign total_slips     = total_slips_r;
`endif

endmodule

// File: tb/tb_comma_align_ctrl.sv
// Self-checking bench for comma_align_ctrl: bit-accurate gearbox stream model with slip offset.
module tb_comma_align_ctrl;

    localparam logic [9:0]  COMMA = 10'b0011111010;
    localparam logic [9:0]  FILL  = 10'b0101010101;
    localparam logic [39:0] PAT   = {COMMA, FILL, FILL, FILL};
    localparam logic [39:0] IDLE  = {FILL, FILL, FILL, FILL};
    localparam logic [39:0] JUNK  = 40'hFF00FF00FF;

    logic        clk = 1'b0;
    logic        rst;
    logic [39:0] data_in;
    logic        valid_in;
    logic        slip_window;
    logic        bitslip;
    logic        locked;
    logic [1:0]  comma_lane;
    logic [3:0]  slip_count;
`ifdef COMMA_ALIGN_STATS_EN
    logic [15:0] lock_loss_count;
    logic [15:0] total_slips;
`endif

    int checks    = 0;
    int errors    = 0;
    int pulses    = 0;
    int bad_slips = 0;
    int off       = 0;
    int exp_q[$];

    comma_align_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .data_in     (data_in),
        .valid_in    (valid_in),
        .slip_window (slip_window),
        .bitslip     (bitslip),
        .locked      (locked),
        .comma_lane  (comma_lane),
        .slip_count  (slip_count)
`ifdef COMMA_ALIGN_STATS_EN
        ,
        .lock_loss_count (lock_loss_count),
        .total_slips     (total_slips)
`endif
    );

    always #5 clk = ~clk;

    // Gearbox output word when the serial stream is rotated left by o bits.
    function automatic logic [39:0] word_at(input int o);
        logic [39:0] p;
        logic [39:0] w;
        p = PAT;
        for (int j = 0; j < 40; j++) begin
            w[39 - j] = p[39 - ((j + o) % 40)];
        end
        return w;
    endfunction

    // One clock: drive at negedge, observe bitslip mid-cycle, apply any slip to the stream model.
    task automatic cyc(input logic v, input logic sw, input logic [39:0] w);
        logic bs;
        @(negedge clk);
        valid_in    = v;
        slip_window = sw;
        data_in     = v ? w : JUNK;
        #1;
        bs = bitslip;
        if (bs) begin
            pulses++;
            if (!sw) bad_slips++;
        end
        @(posedge clk);
        if (bs) off = (off + 1) % 40;
        #1;
    endtask

    task automatic words(input int n, input logic sw, input logic [39:0] w);
        for (int i = 0; i < n; i++) cyc(1'b1, sw, w);
    endtask

    task automatic do_reset;
        @(negedge clk);
        rst = 1'b1; valid_in = 1'b0; slip_window = 1'b0; data_in = IDLE;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0; bad_slips = 0; off = 0;
    endtask

    task automatic test_reset;
        rst = 1'b1; valid_in = 1'b0; slip_window = 1'b1; data_in = JUNK;
        repeat (2) @(negedge clk);
        checks++; if (bitslip !== 1'b0) begin errors++; $display("FAIL reset_bitslip: got %b expected 0", bitslip); end
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked: got %b expected 0", locked); end
        checks++; if (comma_lane !== 2'd0) begin errors++; $display("FAIL reset_lane: got %0d expected 0", comma_lane); end
        checks++; if (slip_count !== 4'd0) begin errors++; $display("FAIL reset_slip_count: got %0d expected 0", slip_count); end
        rst = 1'b0;
    endtask

    task automatic test_aligned_lock;
        do_reset();
        words(511, 1'b1, word_at(0));
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL lock_early: got %b expected 0 after 511 words", locked); end
        words(1, 1'b1, word_at(0));
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL lock_512: got %b expected 1", locked); end
        checks++; if (comma_lane !== 2'd0) begin errors++; $display("FAIL lock_lane: got %0d expected 0", comma_lane); end
        checks++; if (slip_count !== 4'd0) begin errors++; $display("FAIL lock_slip_count: got %0d expected 0", slip_count); end
        checks++; if (pulses != 0) begin errors++; $display("FAIL lock_no_slip: got %0d pulses expected 0", pulses); end
    endtask

    task automatic test_lane_priority;
        logic [39:0] two;
        two = {FILL, COMMA, FILL, COMMA};
        do_reset();
        cyc(1'b1, 1'b1, word_at(20));
        checks++; if (comma_lane !== 2'd2) begin errors++; $display("FAIL lane_two: got %0d expected 2", comma_lane); end
        cyc(1'b1, 1'b1, two);
        checks++; if (comma_lane !== 2'd1) begin errors++; $display("FAIL lane_lowest: got %0d expected 1", comma_lane); end
    endtask

    task automatic test_offset_slips;
        int n;
        int p;
        int e;
        do_reset();
        off = 37;
        exp_q.delete();
        for (int k = 1; k <= 3; k++) exp_q.push_back(k);
        n = 0;
        while (!locked && n < 3000) begin
            p = pulses;
            cyc((n % 5) != 4, (n % 5) != 0, word_at(off));
            if (pulses != p) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
                checks++;
                if (int'(slip_count) != e) begin
                    errors++; $display("FAIL offset_slip_step: got slip_count %0d expected %0d", slip_count, e);
                end
            end
            n++;
        end
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL offset_lock_timeout: got locked %b expected 1", locked); end
        checks++; if (pulses != 3) begin errors++; $display("FAIL offset_pulses: got %0d expected 3", pulses); end
        checks++; if (bad_slips != 0) begin errors++; $display("FAIL offset_window: got %0d off-window pulses expected 0", bad_slips); end
        checks++; if (slip_count !== 4'd3) begin errors++; $display("FAIL offset_slip_count: got %0d expected 3", slip_count); end
        checks++; if (comma_lane !== 2'd0) begin errors++; $display("FAIL offset_lane: got %0d expected 0", comma_lane); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL offset_queue: got %0d pending expected 0", exp_q.size()); end
    endtask

    task automatic test_slip_window_hold;
        do_reset();
        off = 37;
        cyc(1'b1, 1'b0, word_at(off));
        for (int i = 0; i < 20; i++) cyc(1'b1, 1'b0, word_at(off));
        checks++; if (pulses != 0) begin errors++; $display("FAIL hold_no_pulse: got %0d expected 0", pulses); end
        cyc(1'b1, 1'b1, word_at(off));
        checks++; if (pulses != 1) begin errors++; $display("FAIL hold_pulse: got %0d expected 1", pulses); end
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, word_at(off));
        checks++; if (pulses != 1) begin errors++; $display("FAIL hold_single: got %0d expected 1", pulses); end
        checks++; if (bad_slips != 0) begin errors++; $display("FAIL hold_window: got %0d expected 0", bad_slips); end
        checks++; if (slip_count !== 4'd1) begin errors++; $display("FAIL hold_slip_count: got %0d expected 1", slip_count); end
    endtask

    task automatic test_unlock;
        do_reset();
        words(512, 1'b1, PAT);
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL unlock_pre: got %b expected 1", locked); end
        words(255, 1'b1, IDLE);
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL unlock_early: got %b expected 1", locked); end
        words(1, 1'b1, IDLE);
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL unlock_drop: got %b expected 0", locked); end
        checks++; if (slip_count !== 4'd0) begin errors++; $display("FAIL unlock_slip_count: got %0d expected 0", slip_count); end
        words(63, 1'b0, IDLE);
        words(1, 1'b0, IDLE);
        checks++; if (pulses != 0) begin errors++; $display("FAIL unlock_search_pulse: got %0d expected 0", pulses); end
        cyc(1'b0, 1'b1, IDLE);
        checks++; if (pulses != 1) begin errors++; $display("FAIL unlock_search_window: got %0d expected 1", pulses); end
    endtask

    task automatic test_err_recovery;
        do_reset();
        words(512, 1'b1, PAT);
        words(192, 1'b1, IDLE);
        words(64, 1'b1, PAT);
        words(192, 1'b1, IDLE);
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL err_cleared: got %b expected 1", locked); end
        words(64, 1'b1, IDLE);
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL err_fourth: got %b expected 0", locked); end
    endtask

    task automatic test_reset_mid_slip;
        do_reset();
        off = 37;
        cyc(1'b1, 1'b0, word_at(off));
        @(negedge clk);
        valid_in = 1'b0; slip_window = 1'b1;
        #1;
        checks++; if (bitslip !== 1'b1) begin errors++; $display("FAIL rst_slip_armed: got %b expected 1", bitslip); end
        rst = 1'b1;
        #1;
        checks++; if (bitslip !== 1'b0) begin errors++; $display("FAIL rst_slip_async: got %b expected 0", bitslip); end
        @(negedge clk);
        rst = 1'b0; slip_window = 1'b0;
        pulses = 0; bad_slips = 0;
        checks++; if (slip_count !== 4'd0) begin errors++; $display("FAIL rst_slip_count: got %0d expected 0", slip_count); end
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL rst_slip_locked: got %b expected 0", locked); end
        cyc(1'b0, 1'b1, IDLE);
        checks++; if (pulses != 0) begin errors++; $display("FAIL rst_slip_state: got %0d pulses expected 0", pulses); end
        cyc(1'b1, 1'b0, word_at(off));
        cyc(1'b0, 1'b1, IDLE);
        checks++; if (pulses != 1) begin errors++; $display("FAIL rst_slip_search: got %0d pulses expected 1", pulses); end
    endtask

`ifdef COMMA_ALIGN_STATS_EN
    task automatic test_stats;
        do_reset();
        for (int i = 0; i < 2; i++) begin
            words(512, 1'b1, PAT);
            words(256, 1'b1, IDLE);
        end
        checks++; if (lock_loss_count !== 16'd2) begin errors++; $display("FAIL stats_losses: got %0d expected 2", lock_loss_count); end
        checks++; if (total_slips !== 16'd0) begin errors++; $display("FAIL stats_slips: got %0d expected 0", total_slips); end
    endtask
`endif

    initial begin
        valid_in = 1'b0; slip_window = 1'b0; data_in = IDLE;
        test_reset();
        test_aligned_lock();
        test_lane_priority();
        test_offset_slips();
        test_slip_window_hold();
        test_unlock();
        test_err_recovery();
        test_reset_mid_slip();
`ifdef COMMA_ALIGN_STATS_EN
        test_stats();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
